// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap_pkg
//  Description : Shared definitions for the SAP CPU and its program loader:
//                default RAM geometry and the loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

    // Default RAM geometry shared with the cpu top level
    localparam int c_addr_w = 4;
    localparam int c_data_w = 8;

    // Loader state encoding
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_load    = 3'd1;
    localparam logic [2:0] c_st_check   = 3'd2;
    localparam logic [2:0] c_st_release = 3'd3;
    localparam logic [2:0] c_st_run     = 3'd4;
    localparam logic [2:0] c_st_error   = 3'd5;

endpackage : sap_pkg
`default_nettype wire

// File: rtl/sap_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sap_program_loader
//  Description : Streams a full RAM image into the CPU programming port while
//                holding the CPU in reset, optionally verifies a trailing
//                modular-sum checksum byte, then releases the CPU to run.
//  Revision    : 1.0 - initial release
// ============================================================================
module sap_program_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W   = c_addr_w,
    parameter int DATA_W   = c_data_w,
    parameter int CHECKSUM = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              pr_mode,
    output logic [ADDR_W-1:0] pr_address,
    output logic [DATA_W-1:0] pr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_index;
    logic [DATA_W-1:0] r_sum;
    logic [ADDR_W-1:0] r_pr_address;
    logic [DATA_W-1:0] r_pr_data;

    logic              w_hs;
    logic              w_last;

    assign w_hs   = in_valid && in_ready;
    // The index wraps after the final image word, so all-ones marks the last one
    assign w_last = &r_index;

    // Sequencer: state, write index, running checksum and the programming bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_index      <= '0;
            r_sum        <= '0;
            r_pr_address <= '0;
            r_pr_data    <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_run, c_st_error: begin
                    if (start) begin
                        r_state <= c_st_load;
                        r_index <= '0;
                        r_sum   <= '0;
                    end
                end
                c_st_load: begin
                    if (w_hs) begin
                        r_pr_address <= r_index;
                        r_pr_data    <= in_data;
                        r_sum        <= r_sum + in_data;
                        r_index      <= r_index + ADDR_W'(1);
                        if (w_last) begin
                            r_state <= (CHECKSUM != 0) ? c_st_check : c_st_release;
                        end
                    end
                end
                c_st_check: begin
                    // The checksum byte is compared only; it never goes to RAM
                    if (w_hs) begin
                        r_state <= (in_data == r_sum) ? c_st_release : c_st_error;
                    end
                end
                c_st_release: begin
                    r_state <= c_st_run;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Output decode of the registered state; pr_mode stays high through
    // CHECK and RELEASE so the last image word is written at least once more
    assign in_ready   = (r_state == c_st_load) || (r_state == c_st_check);
    assign busy       = (r_state == c_st_load) || (r_state == c_st_check) ||
                        (r_state == c_st_release);
    assign pr_mode    = busy;
    assign cpu_rst    = (r_state != c_st_run);
    assign done       = (r_state == c_st_run);
    assign error      = (r_state == c_st_error);
    assign pr_address = r_pr_address;
    assign pr_data    = r_pr_data;

endmodule : sap_program_loader
`default_nettype wire

// File: tb/tb_sap_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sap_program_loader
//  Description : Self-checking bench for sap_program_loader. A behavioural
//                RAM model captures the programming port; expected images,
//                checksums and latencies are computed from the load rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_program_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // DUT with checksum phase
    logic       start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, pr_mode, cpu_rst, busy, done, error;
    logic [3:0] pr_address;
    logic [7:0] pr_data;

    // DUT without checksum phase
    logic       start1 = 1'b0, in_valid1 = 1'b0;
    logic [7:0] in_data1 = 8'h00;
    logic       in_ready1, pr_mode1, cpu_rst1, busy1, done1, error1;
    logic [3:0] pr_address1;
    logic [7:0] pr_data1;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    logic [7:0] img [16];
    logic [7:0] ram [16];
    bit         ram_clr = 1'b0;

    sap_program_loader #(.ADDR_W(4), .DATA_W(8), .CHECKSUM(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .pr_mode(pr_mode),
        .pr_address(pr_address), .pr_data(pr_data), .cpu_rst(cpu_rst),
        .busy(busy), .done(done), .error(error)
    );

    sap_program_loader #(.ADDR_W(4), .DATA_W(8), .CHECKSUM(0)) u_dut_nochk (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1),
        .in_data(in_data1), .in_ready(in_ready1), .pr_mode(pr_mode1),
        .pr_address(pr_address1), .pr_data(pr_data1), .cpu_rst(cpu_rst1),
        .busy(busy1), .done(done1), .error(error1)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    // CPU RAM model: writes pr_data to pr_address on every edge in programming mode
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'hxx;
        end else if (pr_mode) begin
            ram[pr_address] <= pr_data;
        end
    end

    function automatic logic [7:0] img_sum();
        int s = 0;
        for (int i = 0; i < 16; i++) s += img[i];
        return 8'(s % 256);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) img[i] = 8'(i * 16);
    endtask

    // Pulse start for one edge, optionally with a byte offered at the same time
    task automatic do_start(input bit with_valid);
        @(negedge clk);
        start    = 1'b1;
        ram_clr  = 1'b1;
        in_valid = with_valid;
        in_data  = 8'hEE;
        @(posedge clk); #1;
        start    = 1'b0;
        ram_clr  = 1'b0;
        in_valid = 1'b0;
    endtask

    // Stream image (+ checksum); mode 0 = valid held, 1 = alternating, 2 = random
    task automatic feed(input logic [7:0] chk, input int mode, input bit noise,
                        input bit expect_ok, output int first_edge);
        logic [7:0] q[$];
        logic [3:0] a0;
        logic [7:0] d0;
        bit         hold;
        bit         tog = 1'b0;
        int         n = 0;
        for (int i = 0; i < 16; i++) q.push_back(img[i]);
        q.push_back(chk);
        first_edge = -1;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = tog;
                default: in_valid = ($urandom_range(0, 1) == 1);
            endcase
            tog     = !tog;
            in_data = q[0];
            start   = noise && ($urandom_range(0, 3) == 0);
            hold    = !in_valid && pr_mode;
            a0      = pr_address;
            d0      = pr_data;
            if (in_valid && in_ready) begin
                if (first_edge < 0) first_edge = cyc + 1;
                void'(q.pop_front());
            end
            @(posedge clk); #1;
            if (hold) begin
                total++;
                if ({pr_address, pr_data} !== {a0, d0}) begin
                    bad++;
                    $display("FAIL hold_stable: got %h/%h want %h/%h", pr_address, pr_data, a0, d0);
                end
            end
            n++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL feed_timeout: %0d bytes left, want 0", q.size());
        end
        if (expect_ok) begin
            total++;
            if ({pr_mode, in_ready, cpu_rst, busy, done, error} !== 6'b101100) begin
                bad++;
                $display("FAIL release_state: got %b want 101100",
                         {pr_mode, in_ready, cpu_rst, busy, done, error});
            end
        end
    endtask

    task automatic wait_end(output int edge_n);
        edge_n = -1;
        for (int i = 0; i < 40; i++) begin
            if (done || error) begin
                edge_n = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (edge_n < 0) begin
            bad++;
            $display("FAIL wait_end: no done/error within 40 cycles");
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (ram[i] !== img[i]) begin
                bad++;
                $display("FAIL %s ram[%0d]: got %h want %h", tag, i, ram[i], img[i]);
            end
        end
    endtask

    task automatic check_run(input string tag);
        total++;
        if ({done, error, cpu_rst, pr_mode, busy, in_ready} !== 6'b100000) begin
            bad++;
            $display("FAIL %s run_outputs: got %b want 100000", tag,
                     {done, error, cpu_rst, pr_mode, busy, in_ready});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({pr_mode, pr_address, pr_data, cpu_rst, in_ready, busy, done, error} !==
            {1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got %b", {pr_mode, pr_address, pr_data, cpu_rst,
                     in_ready, busy, done, error});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({cpu_rst, busy, in_ready} !== 3'b100) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want 100", {cpu_rst, busy, in_ready});
        end
    endtask

    task automatic test_full_load();
        int fe, re;
        fill_ramp();
        total++;
        if (img_sum() !== 8'h80) begin
            bad++;
            $display("FAIL ramp_checksum: got %h want 80", img_sum());
        end
        do_start(1'b1);
        total++;
        if ({in_ready, pr_mode, cpu_rst, busy} !== 4'b1111) begin
            bad++;
            $display("FAIL start_latency: got %b want 1111", {in_ready, pr_mode, cpu_rst, busy});
        end
        feed(img_sum(), 0, 1'b0, 1'b1, fe);
        wait_end(re);
        total++;
        if (re - fe + 1 != 18) begin
            bad++;
            $display("FAIL full_load_cycles: got %0d want 18", re - fe + 1);
        end
        check_run("full_load");
        check_ram("full_load");
    endtask

    task automatic test_bad_checksum();
        int fe, re;
        fill_ramp();
        do_start(1'b0);
        feed(img_sum() + 8'd1, 0, 1'b0, 1'b0, fe);
        wait_end(re);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({error, cpu_rst, pr_mode, done, busy, in_ready} !== 6'b110000) begin
            bad++;
            $display("FAIL bad_checksum: got %b want 110000",
                     {error, cpu_rst, pr_mode, done, busy, in_ready});
        end
        fill_random();
        do_start(1'b0);
        total++;
        if ({error, busy} !== 2'b01) begin
            bad++;
            $display("FAIL error_clear_on_start: got %b want 01", {error, busy});
        end
        feed(img_sum(), 2, 1'b0, 1'b1, fe);
        wait_end(re);
        check_run("recover");
        check_ram("recover");
    endtask

    task automatic test_throttled();
        int fe, re;
        fill_ramp();
        do_start(1'b0);
        feed(img_sum(), 1, 1'b0, 1'b1, fe);
        wait_end(re);
        check_run("alternate");
        check_ram("alternate");
        for (int k = 0; k < 3; k++) begin
            fill_random();
            do_start(1'b0);
            feed(img_sum(), 2, 1'b0, 1'b1, fe);
            wait_end(re);
            check_run("random");
            check_ram("random");
        end
    endtask

    task automatic test_reset_midload();
        int fe, re;
        fill_random();
        do_start(1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = img[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({pr_mode, pr_address, pr_data, cpu_rst, in_ready, busy, done, error} !==
            {1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midload_reset: got %b", {pr_mode, pr_address, pr_data, cpu_rst,
                     in_ready, busy, done, error});
        end
        total++;
        if (ram[5] !== img[5]) begin
            bad++;
            $display("FAIL partial_image: got %h want %h", ram[5], img[5]);
        end
        @(negedge clk);
        rst = 1'b0;
        fill_random();
        do_start(1'b0);
        feed(img_sum(), 0, 1'b0, 1'b1, fe);
        wait_end(re);
        check_run("after_reset");
        check_ram("after_reset");
    endtask

    task automatic test_restart();
        int fe, re;
        do_start(1'b0);
        total++;
        if ({cpu_rst, done, busy} !== 3'b101) begin
            bad++;
            $display("FAIL restart_from_run: got %b want 101", {cpu_rst, done, busy});
        end
        fill_random();
        feed(img_sum(), 2, 1'b1, 1'b1, fe);
        wait_end(re);
        check_run("start_noise");
        check_ram("start_noise");
    endtask

    task automatic test_no_checksum();
        int hs = 0, fe = -1, re = -1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1    = 1'b0;
        in_valid1 = 1'b1;
        in_data1  = 8'hA5;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (in_valid1 && in_ready1) begin
                hs++;
                if (fe < 0) fe = cyc + 1;
            end
            @(posedge clk); #1;
            if (done1 && re < 0) re = cyc;
        end
        in_valid1 = 1'b0;
        total++;
        if (hs != 16) begin
            bad++;
            $display("FAIL nochk_bytes: got %0d want 16", hs);
        end
        total++;
        if (re - fe + 1 != 17) begin
            bad++;
            $display("FAIL nochk_cycles: got %0d want 17", re - fe + 1);
        end
        total++;
        if ({done1, error1, cpu_rst1, pr_mode1, in_ready1, pr_address1, pr_data1} !==
            {5'b10000, 4'hF, 8'hA5}) begin
            bad++;
            $display("FAIL nochk_final: got %b", {done1, error1, cpu_rst1, pr_mode1,
                     in_ready1, pr_address1, pr_data1});
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_bad_checksum();
        test_throttled();
        test_reset_midload();
        test_restart();
        test_no_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sap_program_loader
`default_nettype wire
